// File: rtl/mmcm_drp_reconfig.sv
// Run-time MMCME2_ADV reconfiguration: walks a config table, read-modify-writes each DRP register
// while the MMCM is held in reset, then releases reset and waits for LOCKED.
module mmcm_drp_reconfig #(
  parameter int NUM_ENTRIES  = 23,
  parameter int DRDY_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  tbl_addr,
  input  logic [38:0] tbl_data,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic        drp_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked
);

  localparam int DTW = (DRDY_TIMEOUT > 2) ? $clog2(DRDY_TIMEOUT) : 1;
  localparam int LTW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ASSERT_RST = 4'd1,
    FETCH      = 4'd2,
    READ       = 4'd3,
    WAIT_RD    = 4'd4,
    WRITE      = 4'd5,
    WAIT_WR    = 4'd6,
    RELEASE    = 4'd7,
    WAIT_LOCK  = 4'd8
  } state_t;

  state_t         state_r;
  logic [7:0]     index_r;
  logic [15:0]    mask_r;
  logic [15:0]    value_r;
  logic           fetch_wait_r;
  logic [DTW-1:0] drp_tmr_r;
  logic [LTW-1:0] lock_tmr_r;
  logic           locked_meta_r;
  logic           locked_sync_r;
  logic           last_entry_s;

  // Mask bit 1 keeps the register's current bit, 0 takes the table value.
  function automatic logic [15:0] merge_bits(input logic [15:0] old_bits,
                                             input logic [15:0] keep,
                                             input logic [15:0] new_bits);
    return (old_bits & keep) | (new_bits & ~keep);
  endfunction

  assign last_entry_s = (index_r == 8'(NUM_ENTRIES - 1));

  // Two-flop synchroniser for the asynchronous LOCKED input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_meta_r <= 1'b0;
      locked_sync_r <= 1'b0;
    end else begin
      locked_meta_r <= mmcm_locked;
      locked_sync_r <= locked_meta_r;
    end
  end

  // Reconfiguration sequencer; all outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      index_r      <= 8'd0;
      mask_r       <= 16'd0;
      value_r      <= 16'd0;
      fetch_wait_r <= 1'b0;
      drp_tmr_r    <= '0;
      lock_tmr_r   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      tbl_addr     <= 8'd0;
      drp_daddr    <= 7'd0;
      drp_di       <= 16'd0;
      drp_den      <= 1'b0;
      drp_dwe      <= 1'b0;
      mmcm_rst     <= 1'b0;
    end else begin
      done    <= 1'b0;
      error   <= 1'b0;
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;
      case (state_r)
        IDLE: begin
          // The cycle carrying done/error is already IDLE; a start there is dropped.
          if (start && !done && !error) begin
            busy     <= 1'b1;
            mmcm_rst <= 1'b1;
            index_r  <= 8'd0;
            tbl_addr <= 8'd0;
            state_r  <= ASSERT_RST;
          end else begin
            state_r <= IDLE;
          end
        end
        ASSERT_RST: begin
          fetch_wait_r <= 1'b1;
          state_r      <= FETCH;
        end
        FETCH: begin
          // First cycle lets the sync ROM respond to a freshly changed tbl_addr.
          if (fetch_wait_r) begin
            fetch_wait_r <= 1'b0;
          end else begin
            drp_daddr <= tbl_data[38:32];
            mask_r    <= tbl_data[31:16];
            value_r   <= tbl_data[15:0];
            drp_den   <= 1'b1;
            state_r   <= READ;
          end
        end
        READ: begin
          drp_tmr_r <= DTW'(1);
          state_r   <= WAIT_RD;
        end
        WAIT_RD: begin
          if (drp_drdy) begin
            drp_di  <= merge_bits(drp_do, mask_r, value_r);
            drp_den <= 1'b1;
            drp_dwe <= 1'b1;
            state_r <= WRITE;
          end else if (drp_tmr_r == DTW'(DRDY_TIMEOUT - 1)) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            drp_tmr_r <= drp_tmr_r + DTW'(1);
          end
        end
        WRITE: begin
          drp_tmr_r <= DTW'(1);
          state_r   <= WAIT_WR;
        end
        WAIT_WR: begin
          if (drp_drdy) begin
            if (last_entry_s) begin
              mmcm_rst   <= 1'b0;
              lock_tmr_r <= '0;
              state_r    <= RELEASE;
            end else begin
              index_r      <= index_r + 8'd1;
              tbl_addr     <= index_r + 8'd1;
              fetch_wait_r <= 1'b1;
              state_r      <= FETCH;
            end
          end else if (drp_tmr_r == DTW'(DRDY_TIMEOUT - 1)) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            drp_tmr_r <= drp_tmr_r + DTW'(1);
          end
        end
        RELEASE: begin
          lock_tmr_r <= LTW'(1);
          state_r    <= WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_sync_r) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (lock_tmr_r == LTW'(LOCK_TIMEOUT - 1)) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            lock_tmr_r <= lock_tmr_r + LTW'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
